pipeline_complex_mult: RTL

Parametrised, fully pipelined signed fixed-point complex multiplier for the fractal iteration datapath. It computes (a_re + j·a_im)·(b_re + j·b_im) in Q(INT_BITS.FRAC_BITS).
- Selectable rounding; selectable saturation or wrap, with a per-sample overflow flag used for escape detection.
- Valid/ready handshake with full-pipeline stall.
- Opaque tag carried alongside each sample (pixel/iteration ID).
- Sits between the iteration controller and the add/escape stage.

---
 rtl/pipeline_complex_mult.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipeline_complex_mult.sv
// Fully pipelined signed fixed-point complex multiplier with rounding, saturation/wrap,
// overflow flag, tag passthrough and valid/ready handshake with whole-pipeline stall.
module pipeline_complex_mult #(
    parameter int INT_BITS     = 4,
    parameter int FRAC_BITS    = 14,
    parameter int EXTRA_STAGES = 0,
    parameter int ROUND        = 0,
    parameter int SATURATE     = 1,
    parameter int TAG_BITS     = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] a_re,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] a_im,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] b_re,
    input  logic signed [INT_BITS+FRAC_BITS-1:0] b_im,
    input  logic        [TAG_BITS-1:0]           in_tag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [INT_BITS+FRAC_BITS-1:0] out_re,
    output logic signed [INT_BITS+FRAC_BITS-1:0] out_im,
    output logic                                out_ovf,
    output logic        [TAG_BITS-1:0]           out_tag
);

    localparam int          N  = INT_BITS + FRAC_BITS;
    localparam int          W  = 2 * N + 2;
    localparam int unsigned NX = EXTRA_STAGES;

    localparam logic signed [W-1:0] RND  = (ROUND != 0) ? (W'(1) <<< (FRAC_BITS - 1)) : '0;
    localparam logic signed [W-1:0] MAXV = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic adv;

    logic                  s1_v;
    logic signed [N-1:0]   s1_ar, s1_ai, s1_br, s1_bi;
    logic [TAG_BITS-1:0]   s1_tag;

    logic                  s2_v;
    logic signed [2*N-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic [TAG_BITS-1:0]   s2_tag;

    logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [W-1:0]   re_w, im_w;
    logic [N:0]            res_re, res_im;

    // Index 0 holds the S3 result; the last index drives the outputs.
    logic                  d_v   [0:NX];
    logic signed [N-1:0]   d_re  [0:NX];
    logic signed [N-1:0]   d_im  [0:NX];
    logic                  d_ovf [0:NX];
    logic [TAG_BITS-1:0]   d_tag [0:NX];

    function automatic logic signed [2*N-1:0] smul(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
        logic signed [2*N-1:0] xe, ye;
        xe = {{N{x[N-1]}}, x};
        ye = {{N{y[N-1]}}, y};
        return xe * ye;
    endfunction

    // Returns {overflow, N-bit result} after rounding, shift and range handling.
    function automatic logic [N:0] scale(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        logic                ovf;
        logic [N-1:0]        q;
        r   = v + RND;
        r   = r >>> FRAC_BITS;
        ovf = (r > MAXV) || (r < MINV);
        q   = r[N-1:0];
        if (ovf && (SATURATE != 0))
            q = r[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        return {ovf, q};
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        p_rr   = smul(s1_ar, s1_br);
        p_ii   = smul(s1_ai, s1_bi);
        p_ri   = smul(s1_ar, s1_bi);
        p_ir   = smul(s1_ai, s1_br);
        re_w   = {{2{s2_rr[2*N-1]}}, s2_rr} - {{2{s2_ii[2*N-1]}}, s2_ii};
        im_w   = {{2{s2_ri[2*N-1]}}, s2_ri} + {{2{s2_ir[2*N-1]}}, s2_ir};
        res_re = scale(re_w);
        res_im = scale(im_w);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_v   <= 1'b0;
            s1_ar  <= '0;
            s1_ai  <= '0;
            s1_br  <= '0;
            s1_bi  <= '0;
            s1_tag <= '0;
            s2_v   <= 1'b0;
            s2_rr  <= '0;
            s2_ii  <= '0;
            s2_ri  <= '0;
            s2_ir  <= '0;
            s2_tag <= '0;
            for (int unsigned i = 0; i <= NX; i++) begin
                d_v[i]   <= 1'b0;
                d_re[i]  <= '0;
                d_im[i]  <= '0;
                d_ovf[i] <= 1'b0;
                d_tag[i] <= '0;
            end
        end else if (adv) begin
            s1_v     <= in_valid;
            s1_ar    <= a_re;
            s1_ai    <= a_im;
            s1_br    <= b_re;
            s1_bi    <= b_im;
            s1_tag   <= in_tag;
            s2_v     <= s1_v;
            s2_rr    <= p_rr;
            s2_ii    <= p_ii;
            s2_ri    <= p_ri;
            s2_ir    <= p_ir;
            s2_tag   <= s1_tag;
            d_v[0]   <= s2_v;
            d_re[0]  <= res_re[N-1:0];
            d_im[0]  <= res_im[N-1:0];
            d_ovf[0] <= res_re[N] | res_im[N];
            d_tag[0] <= s2_tag;
            for (int unsigned i = 1; i <= NX; i++) begin
                d_v[i]   <= d_v[i-1];
                d_re[i]  <= d_re[i-1];
                d_im[i]  <= d_im[i-1];
                d_ovf[i] <= d_ovf[i-1];
                d_tag[i] <= d_tag[i-1];
            end
        end
    end

    assign out_valid = d_v[NX];
    assign out_re    = d_re[NX];
    assign out_im    = d_im[NX];
    assign out_ovf   = d_ovf[NX];
    assign out_tag   = d_tag[NX];

endmodule
